pwm_audio_out: RTL and testbench

Output stage of the sound card: accepts the mixed 8-bit unsigned samples produced by the channel adder through a valid/ready handshake and buffers them in a small FIFO. It converts each sample into one frame of pulse-width modulation on a single pin that drives an external RC low-pass filter and amplifier. One sample is consumed per PWM frame of 2^SAMPLE_W clocks. The block reports underruns when the producer falls behind.

---
 rtl/audio_pkg.sv | 13 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/pwm_audio_out.sv | 101 ++++++++++
 tb/tb_pwm_audio_out.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the sound card PWM output stage.
package audio_pkg;

   localparam int unsigned DEF_SAMPLE_W = 8;

   typedef logic [DEF_SAMPLE_W-1:0] sample_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always visible on rd_data.
module sample_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses a push even if the same edge pops.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: FIFO-buffered samples, one sample played per 2^SAMPLE_W-clock frame.
module pwm_audio_out
   import audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                pwm_out,
   output logic                frame_start,
   output logic                underrun
);

   localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

   pwm_state_t          state;
   pwm_state_t          state_nxt;
   logic [SAMPLE_W-1:0] cnt;
   logic [SAMPLE_W-1:0] cnt_nxt;
   logic [SAMPLE_W-1:0] duty;
   logic [SAMPLE_W-1:0] duty_nxt;
   logic [SAMPLE_W-1:0] fifo_data;
   logic                underrun_q;
   logic                underrun_nxt;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (sample_valid),
      .wr_data (sample_in),
      .pop     (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // State register plus the frame counter, latched duty and underrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         duty       <= '0;
         underrun_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         duty       <= duty_nxt;
         underrun_q <= underrun_nxt;
      end
   end

   // Samples are only taken at frame boundaries; an empty FIFO there replays the old duty.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      duty_nxt     = duty;
      underrun_nxt = 1'b0;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable && !fifo_empty) begin
               pop       = 1'b1;
               duty_nxt  = fifo_data;
               state_nxt = RUN;
            end
         end
         RUN: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_MAX) begin
               if (!enable) begin
                  state_nxt = IDLE;
               end else if (!fifo_empty) begin
                  pop      = 1'b1;
                  duty_nxt = fifo_data;
               end else begin
                  underrun_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sample_ready = !fifo_full;
   assign pwm_out      = (state == RUN) && (cnt < duty);
   assign frame_start  = (state == RUN) && (cnt == '0);
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: per-cycle reference model plus per-frame high-time counts.
module tb_pwm_audio_out;

   localparam int unsigned DEPTH = 4;
   localparam int FRAME = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] sample_in = 8'h00;
   logic       sample_valid = 1'b0;
   logic       sample_ready;
   logic       pwm_out;
   logic       frame_start;
   logic       underrun;

   always #5 clk = ~clk;

   pwm_audio_out #(
      .SAMPLE_W   (8),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of buffered samples, playing flag, position in frame, current duty.
   int q[$];
   bit m_run;
   int m_pos;
   int m_duty;
   bit m_ur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_run  = 1'b0;
      m_pos  = 0;
      m_duty = 0;
      m_ur   = 1'b0;
   endtask

   task automatic model_edge(input bit pv, input int s, input bit en);
      bit accept;
      accept = pv && (q.size() < DEPTH);
      m_ur = 1'b0;
      if (!m_run) begin
         if (en && q.size() > 0) begin
            m_duty = q.pop_front();
            m_run  = 1'b1;
            m_pos  = 0;
         end
      end else if (m_pos == FRAME - 1) begin
         m_pos = 0;
         if (!en) m_run = 1'b0;
         else if (q.size() > 0) m_duty = q.pop_front();
         else m_ur = 1'b1;
      end else begin
         m_pos++;
      end
      if (accept) q.push_back(s & 255);
   endtask

   task automatic check_outputs(input string ph);
      chk({ph, ":pwm_out"},      32'(pwm_out),      32'(m_run && (m_pos < m_duty)));
      chk({ph, ":frame_start"},  32'(frame_start),  32'(m_run && (m_pos == 0)));
      chk({ph, ":underrun"},     32'(underrun),     32'(m_ur));
      chk({ph, ":sample_ready"}, 32'(sample_ready), 32'(q.size() < DEPTH));
   endtask

   task automatic cyc(input bit pv, input int s, input bit en);
      sample_valid = pv;
      sample_in    = 8'(s);
      enable       = en;
      @(posedge clk);
      model_edge(pv, s, en);
      #1;
      check_outputs("cyc");
   endtask

   // Count high clocks across one full frame starting at the current frame_start cycle.
   task automatic measure_frame(input int exp_hi, input bit pv, input int s, input bit en,
                                input string tag);
      int hi;
      hi = 0;
      chk({tag, ":frame_start"}, 32'(frame_start), 32'd1);
      for (int i = 0; i < FRAME; i++) begin
         hi += int'(pwm_out);
         cyc((i == 0) ? pv : 1'b0, s, en);
      end
      chk({tag, ":high_clocks"}, 32'(hi), 32'(exp_hi));
   endtask

   initial begin
      int hi;
      bit en_r;

      // Reset values
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      rst_n = 1'b1;
      cyc(1'b0, 0, 1'b0);
      cyc(1'b0, 0, 1'b0);

      // Duty patterns, with next sample supplied during each frame
      cyc(1'b1, 'h40, 1'b1);
      cyc(1'b0, 0, 1'b1);
      measure_frame(64, 1'b1, 'h00, 1'b1, "duty40");
      measure_frame(0, 1'b1, 'hFF, 1'b1, "duty00");
      measure_frame(255, 1'b0, 0, 1'b1, "dutyFF");

      // Underrun replays the previous duty
      chk("underrun_after_ff", 32'(underrun), 32'd1);
      measure_frame(255, 1'b1, 'h80, 1'b1, "repeatFF");
      measure_frame(128, 1'b0, 0, 1'b1, "duty80");
      chk("underrun_after_80", 32'(underrun), 32'd1);
      measure_frame(128, 1'b0, 0, 1'b1, "repeat80");

      // Push on the exact empty-FIFO boundary edge
      repeat (255) cyc(1'b0, 0, 1'b1);
      cyc(1'b1, 'h33, 1'b1);
      chk("boundary_underrun", 32'(underrun), 32'd1);
      measure_frame(128, 1'b0, 0, 1'b1, "boundary80");
      measure_frame('h33, 1'b0, 0, 1'b1, "boundary33");

      // Stop mid-frame: frame completes, then idle with samples retained
      hi = 0;
      chk("stop:frame_start", 32'(frame_start), 32'd1);
      for (int i = 0; i < FRAME; i++) begin
         hi += int'(pwm_out);
         cyc(i < 2, (i == 0) ? 'h11 : 'h22, i < 10);
      end
      chk("stop:high_clocks", 32'(hi), 32'h33);
      chk("stop:idle_pwm", 32'(pwm_out), 32'd0);
      chk("stop:idle_frame_start", 32'(frame_start), 32'd0);
      repeat (20) cyc(1'b0, 0, 1'b0);
      chk("stop:ready", 32'(sample_ready), 32'd1);
      cyc(1'b0, 0, 1'b1);
      measure_frame('h11, 1'b0, 0, 1'b1, "resume11");
      measure_frame('h22, 1'b0, 0, 1'b0, "resume22");
      cyc(1'b0, 0, 1'b0);

      // Back-pressure: fifth sample stalls until a pop frees a slot
      for (int k = 1; k <= 5; k++) cyc(1'b1, k, 1'b0);
      chk("bp:ready_full", 32'(sample_ready), 32'd0);
      repeat (3) cyc(1'b1, 5, 1'b0);
      chk("bp:still_full", 32'(sample_ready), 32'd0);
      cyc(1'b1, 5, 1'b1);
      chk("bp:ready_after_pop", 32'(sample_ready), 32'd1);
      measure_frame(1, 1'b1, 5, 1'b1, "bp1");
      measure_frame(2, 1'b0, 0, 1'b1, "bp2");
      measure_frame(3, 1'b0, 0, 1'b1, "bp3");
      measure_frame(4, 1'b0, 0, 1'b1, "bp4");
      measure_frame(5, 1'b0, 0, 1'b0, "bp5");

      // Randomized traffic against the model
      en_r = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) en_r = ~en_r;
         cyc($urandom_range(0, 63) == 0, int'($urandom_range(0, 255)), en_r);
      end

      // Reset asserted mid-frame with three samples queued
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      cyc(1'b1, 'h90, 1'b1);
      cyc(1'b1, 'hA0, 1'b1);
      cyc(1'b1, 'hB0, 1'b1);
      cyc(1'b1, 'hC0, 1'b1);
      repeat (50) cyc(1'b0, 0, 1'b1);
      chk("pre_rst:pwm_high", 32'(pwm_out), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_mid");
      repeat (3) @(posedge clk);
      #1;
      check_outputs("rst_hold");
      rst_n = 1'b1;
      repeat (300) cyc(1'b0, 0, 1'b1);
      chk("post_rst:no_frame", 32'(frame_start), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
